// File: rtl/memory_write_responder_pkg.sv
// memory_write_responder_pkg: response codes and hold-register layout shared by the write responder
// Contents:
//   RESP_OKAY / RESP_SLVERR  write-response encodings (only these two are ever driven)
//   HOLD_FLAG_BITS           width of the held flag stored above the payload in a hold slot
//   addr_in_range            true when a word address maps onto an implemented memory word
package memory_write_responder_pkg;
    localparam logic RESP_OKAY      = 1'b0;
    localparam logic RESP_SLVERR    = 1'b1;
    localparam int   HOLD_FLAG_BITS = 1;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction
endpackage

// File: rtl/memory_write_responder_chan_hold.sv
// chan_hold_reg: single-beat valid/ready capture register for one write channel
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   valid      incoming beat valid
//   ready      high while the slot is empty
//   data       incoming beat payload
//   clear      empties the slot (write committed)
//   held       slot holds a beat
//   held_data  payload of the held beat
module chan_hold_reg
    import memory_write_responder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic             held,
    output logic [WIDTH-1:0] held_data
);
    // slot = {held flag, payload}
    logic [WIDTH+HOLD_FLAG_BITS-1:0] slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot <= '0;
        else if (clear)
            slot <= '0;
        else if (valid && ready)
            slot <= {1'b1, data};
    end

    assign held      = slot[WIDTH];
    assign ready     = !held;
    assign held_data = slot[WIDTH-1:0];
endmodule

// File: rtl/memory_write_responder.sv
// memory_write_responder: memory-side AW/W/B responder with word array, B slot and read-back port
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   aw_valid/aw_ready/aw_address  write-address channel
//   w_valid/w_ready/w_data        write-data channel
//   b_valid/b_ready/b_resp        write-response channel (OKAY=0, SLVERR=1)
//   wr_count                      saturating count of OKAY writes since reset
//   rd_addr/rd_data               combinational read-back, 0 outside the implemented words
module memory_write_responder
    import memory_write_responder_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int MEM_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] aw_address,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp,
    output logic [ADDR_WDTH:0]   wr_count,
    input  logic [ADDR_WDTH-1:0] rd_addr,
    output logic [DATA_WDTH-1:0] rd_data
);
    localparam logic [ADDR_WDTH:0] CNT_MAX = '1;

    logic                 aw_held, w_held, commit, in_range;
    logic [ADDR_WDTH-1:0] addr;
    logic [DATA_WDTH-1:0] data;
    logic [DATA_WDTH-1:0] mem [MEM_DEPTH];

    chan_hold_reg #(.WIDTH(ADDR_WDTH)) u_aw (
        .clk(clk), .rst(rst), .valid(aw_valid), .ready(aw_ready), .data(aw_address),
        .clear(commit), .held(aw_held), .held_data(addr)
    );

    chan_hold_reg #(.WIDTH(DATA_WDTH)) u_w (
        .clk(clk), .rst(rst), .valid(w_valid), .ready(w_ready), .data(w_data),
        .clear(commit), .held(w_held), .held_data(data)
    );

    // A commit needs both beats and a B slot that is empty or being emptied this cycle
    assign commit   = aw_held && w_held && (!b_valid || b_ready);
    assign in_range = addr_in_range(32'(addr), MEM_DEPTH);

    // Memory is deliberately outside the reset domain so contents survive rst
    always_ff @(posedge clk) begin
        if (commit && in_range)
            mem[addr] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid  <= 1'b0;
            b_resp   <= '0;
            wr_count <= '0;
        end else begin
            if (commit) begin
                b_valid <= 1'b1;
                b_resp  <= in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
            end else if (b_ready) begin
                b_valid <= 1'b0;
            end
            if (commit && in_range && wr_count != CNT_MAX)
                wr_count <= wr_count + 1'b1;
        end
    end

    assign rd_data = addr_in_range(32'(rd_addr), MEM_DEPTH) ? mem[rd_addr] : '0;
endmodule
